// File: rtl/fp_join_pkg.sv
// Shared types for the FP operand joiner: one operand beat, one paired output beat,
// and the FIFO pointer-width helper.
package fp_join_pkg;

    // Operand width lives here because the beat/pair typedefs are built from it.
    localparam int BW  = 32;
    localparam int BWB = BW / 8;

    typedef struct packed {
        logic [BW-1:0]  data;
        logic [BWB-1:0] keep;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [2*BW-1:0]  data;
        logic [2*BWB-1:0] keep;
        logic             last;
    } pair_t;

    // One extra bit over the address so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fp_join_if.sv
// AXI-Stream bundle for the joiner: operand streams A and B in, paired stream out.
interface fp_join_if;
    import fp_join_pkg::*;

    // Every stream: a beat transfers on a rising clock edge where TVALID and TREADY are
    // both high; a source holds TVALID and its payload stable until that edge, and
    // TVALID never waits on TREADY.
    logic              a_TVALID;
    logic [BW-1:0]     a_TDATA;
    logic [BWB-1:0]    a_TKEEP;
    logic              a_TLAST;
    logic              a_TREADY;

    logic              b_TVALID;
    logic [BW-1:0]     b_TDATA;
    logic [BWB-1:0]    b_TKEEP;
    logic              b_TLAST;
    logic              b_TREADY;

    logic              out_TVALID;
    logic [2*BW-1:0]   out_TDATA;
    logic [2*BWB-1:0]  out_TKEEP;
    logic              out_TLAST;
    logic              out_TREADY;

    modport slave (
        input  a_TVALID, a_TDATA, a_TKEEP, a_TLAST,
        output a_TREADY,
        input  b_TVALID, b_TDATA, b_TKEEP, b_TLAST,
        output b_TREADY,
        output out_TVALID, out_TDATA, out_TKEEP, out_TLAST,
        input  out_TREADY
    );

    modport master (
        output a_TVALID, a_TDATA, a_TKEEP, a_TLAST,
        input  a_TREADY,
        output b_TVALID, b_TDATA, b_TKEEP, b_TLAST,
        input  b_TREADY,
        input  out_TVALID, out_TDATA, out_TKEEP, out_TLAST,
        output out_TREADY
    );

endinterface

// File: rtl/fp_join_fifo.sv
// Per-operand beat FIFO with registered empty and registered ready (= not full).
// Ready is held low in reset and rises on the first edge after release.
module fp_join_fifo
    import fp_join_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  valid_i,
    input  beat_t wdata_i,
    output logic  ready_o,
    input  logic  pop_i,
    output beat_t rdata_o,
    output logic  empty_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          empty_q, empty_d;
    logic          ready_q, full_d;
    logic          push;
    beat_t         mem_q [DEPTH];

    // The caller only pops when not empty; push is gated here by our own ready.
    assign push = valid_i && ready_q;

    always_comb begin
        wr_d    = push  ? wr_q + PW'(1) : wr_q;
        rd_d    = pop_i ? rd_q + PW'(1) : rd_q;
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[PW-1] != rd_d[PW-1]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            empty_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            empty_q <= empty_d;
            ready_q <= !full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign empty_o = empty_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/fp_operand_joiner.sv
// Pairs one A beat with one B beat into a registered {B,A} output beat; counts output
// handshakes and keeps a sticky flag for pairs whose TLASTs disagree.
module fp_operand_joiner
    import fp_join_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_high,
    fp_join_if.slave         io,
    input  logic             clear,
    output logic [CNT_W-1:0] pair_count,
    output logic             last_mismatch
);

    beat_t            a_in, b_in, a_head, b_head;
    logic             a_empty, b_empty;
    logic             fire, hs;
    pair_t            out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;

    assign a_in = '{data: io.a_TDATA, keep: io.a_TKEEP, last: io.a_TLAST};
    assign b_in = '{data: io.b_TDATA, keep: io.b_TKEEP, last: io.b_TLAST};

    fp_join_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk_i   (clk_line),
        .rst_i   (clk_line_rst_high),
        .valid_i (io.a_TVALID),
        .wdata_i (a_in),
        .ready_o (io.a_TREADY),
        .pop_i   (fire),
        .rdata_o (a_head),
        .empty_o (a_empty)
    );

    fp_join_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk_i   (clk_line),
        .rst_i   (clk_line_rst_high),
        .valid_i (io.b_TVALID),
        .wdata_i (b_in),
        .ready_o (io.b_TREADY),
        .pop_i   (fire),
        .rdata_o (b_head),
        .empty_o (b_empty)
    );

    // A pair moves only when both heads exist and the output slot is free or draining.
    always_comb begin
        fire  = !a_empty && !b_empty && (!out_valid_q || io.out_TREADY);
        hs    = out_valid_q && io.out_TREADY;
        out_d = out_q;
        if (fire) begin
            out_d = '{data: {b_head.data, a_head.data},
                      keep: {b_head.keep, a_head.keep},
                      last: a_head.last | b_head.last};
        end
        out_valid_d = fire ? 1'b1 : (io.out_TREADY ? 1'b0 : out_valid_q);
        cnt_d = clear ? '0 : (hs ? cnt_q + CNT_W'(1) : cnt_q);
        mis_d = clear ? 1'b0 : ((fire && (a_head.last != b_head.last)) ? 1'b1 : mis_q);
    end

    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            mis_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            mis_q       <= mis_d;
        end
    end

    assign io.out_TVALID = out_valid_q;
    assign io.out_TDATA  = out_q.data;
    assign io.out_TKEEP  = out_q.keep;
    assign io.out_TLAST  = out_q.last;
    assign pair_count    = cnt_q;
    assign last_mismatch = mis_q;

endmodule
